// File: rtl/serial_sub32_if.sv
// Handshake and data bundle for the chunked subtractor.
// master: operand producer / result consumer; slave: the subtractor itself.
interface serial_sub32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  borrow,
        input  ovf,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output borrow,
        output ovf,
        output zero
    );
endinterface

// File: rtl/serial_sub32.sv
// Multi-cycle chunked subtractor: a - b over WIDTH bits, CHUNK bits per
// clock, LSB chunk first, with a registered borrow carried between chunks.
// Result plus borrow / signed-overflow / zero flags are presented with a
// valid/ready handshake and held until the next operation overwrites them.
module serial_sub32 #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_sub32_if.slave  bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow;
    logic [IDXW-1:0]   r_idx;
    logic              r_flag_borrow;
    logic              r_ovf;
    logic              r_zero;

    logic              w_accept;
    logic              w_run;
    logic              w_last;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_t;
    logic [WIDTH-1:0]  w_diff_next;
    logic              w_ovf_next;
    logic              w_zero_next;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (r_idx == IDXW'(N - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Chunk subtraction for the current index, and the diff word it produces.
    always_comb begin
        w_a_chunk   = '0;
        w_b_chunk   = '0;
        w_diff_next = r_diff;
        for (int unsigned j = 0; j < N; j++) begin
            if (r_idx == IDXW'(j)) begin
                w_a_chunk = r_a[j*CHUNK +: CHUNK];
                w_b_chunk = r_b[j*CHUNK +: CHUNK];
            end
        end
        w_t = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};
        for (int unsigned j = 0; j < N; j++) begin
            if (r_idx == IDXW'(j)) begin
                w_diff_next[j*CHUNK +: CHUNK] = w_t[CHUNK-1:0];
            end
        end
        w_ovf_next  = (r_a[MSB] != r_b[MSB]) && (w_diff_next[MSB] != r_a[MSB]);
        w_zero_next = (w_diff_next == '0);
    end

    // Operand capture, chunk datapath and flag registers.
    // Flags are latched on the final chunk edge from the completed diff word,
    // so they hold steady through DONE and IDLE until the next operation ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a           <= '0;
            r_b           <= '0;
            r_diff        <= '0;
            r_borrow      <= 1'b0;
            r_idx         <= '0;
            r_flag_borrow <= 1'b0;
            r_ovf         <= 1'b0;
            r_zero        <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_idx    <= '0;
            r_borrow <= 1'b0;
        end else if (w_run) begin
            r_diff   <= w_diff_next;
            r_borrow <= w_t[CHUNK];
            if (w_last) begin
                r_idx         <= '0;
                r_flag_borrow <= w_t[CHUNK];
                r_ovf         <= w_ovf_next;
                r_zero        <= w_zero_next;
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_flag_borrow;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_serial_sub32.sv
// Bench for serial_sub32: directed vector table, randomized operations
// against an arithmetic reference, backpressure and asynchronous reset.
module tb_serial_sub32;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = WIDTH / CHUNK;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    serial_sub32_if #(.WIDTH(WIDTH)) u_if ();

    serial_sub32 #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference: plain modular, unsigned and signed arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic bo,
                                  output logic ov, output logic ze);
        longint sd;
        d  = a - b;
        bo = (a < b);
        sd = longint'($signed(a)) - longint'($signed(b));
        ov = (sd > SMAX) || (sd < SMIN);
        ze = (d == 32'd0);
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is seen.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        int g;
        g = 0;
        while (!u_if.in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!u_if.in_ready) chk("in_ready_timeout", 64'(u_if.in_ready), 64'd1);
        u_if.in_valid = 1'b1;
        u_if.a = a;
        u_if.b = b;
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.a = $urandom;
        u_if.b = $urandom;
        lat = 0;
        while (!u_if.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic retire();
        u_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.out_ready = 1'b0;
        chk("retire_out_valid", 64'(u_if.out_valid), 64'd0);
        chk("retire_in_ready", 64'(u_if.in_ready), 64'd1);
    endtask

    task automatic check_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input int hold);
        int lat;
        logic [31:0] d;
        logic bo, ov, ze;
        model(a, b, d, bo, ov, ze);
        start_op(a, b, lat);
        chk({nm, "_latency"}, 64'(lat), 64'(NCH));
        chk({nm, "_diff"}, 64'(u_if.diff), 64'(d));
        chk({nm, "_borrow"}, 64'(u_if.borrow), 64'(bo));
        chk({nm, "_ovf"}, 64'(u_if.ovf), 64'(ov));
        chk({nm, "_zero"}, 64'(u_if.zero), 64'(ze));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 64'(u_if.out_valid), 64'd1);
            chk({nm, "_hold_diff"}, 64'(u_if.diff), 64'(d));
        end
        retire();
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb, hold_diff;
        logic hold_b, hold_o, hold_z;
        errors = 0;
        checks = 0;

        vecs[0] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        u_if.a = '0;
        u_if.b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(u_if.in_ready), 64'd1);
        chk("rst_out_valid", 64'(u_if.out_valid), 64'd0);
        chk("rst_diff", 64'(u_if.diff), 64'd0);
        chk("rst_flags", {61'd0, u_if.borrow, u_if.ovf, u_if.zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NCH));
            chk($sformatf("vec%0d_diff", i), 64'(u_if.diff), 64'(vecs[i].diff));
            chk($sformatf("vec%0d_borrow", i), 64'(u_if.borrow), 64'(vecs[i].borrow));
            chk($sformatf("vec%0d_ovf", i), 64'(u_if.ovf), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d_zero", i), 64'(u_if.zero), 64'(vecs[i].zero));
            retire();
        end

        // Randomized operations against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 5)
                0: rb = ra;
                1: rb = ra + 32'd1;
                2: rb = ra ^ 32'h8000_0000;
                default: ;
            endcase
            check_op($sformatf("rnd%0d", i), ra, rb, int'($urandom_range(0, 3)));
        end

        // Backpressure: new operands offered during DONE must be ignored
        start_op(32'h0000_1000, 32'h0000_0FFF, lat);
        chk("bp_latency", 64'(lat), 64'(NCH));
        hold_diff = u_if.diff;
        hold_b = u_if.borrow;
        hold_o = u_if.ovf;
        hold_z = u_if.zero;
        chk("bp_diff", 64'(hold_diff), 64'h1);
        u_if.in_valid = 1'b1;
        u_if.a = 32'h0000_0055;
        u_if.b = 32'h0000_0011;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(u_if.out_valid), 64'd1);
            chk("bp_in_ready", 64'(u_if.in_ready), 64'd0);
            chk("bp_diff_hold", 64'(u_if.diff), 64'(hold_diff));
            chk("bp_flags_hold", {61'd0, u_if.borrow, u_if.ovf, u_if.zero},
                {61'd0, hold_b, hold_o, hold_z});
        end
        u_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.out_ready = 1'b0;
        chk("bp_idle_out_valid", 64'(u_if.out_valid), 64'd0);
        chk("bp_idle_in_ready", 64'(u_if.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        chk("bp_accepted", 64'(u_if.in_ready), 64'd0);
        lat = 0;
        while (!u_if.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_new_latency", 64'(lat), 64'(NCH));
        chk("bp_new_diff", 64'(u_if.diff), 64'h44);
        retire();

        // Asynchronous reset during the second RUN cycle
        u_if.in_valid = 1'b1;
        u_if.a = 32'h0000_1000;
        u_if.b = 32'h0000_0001;
        @(posedge clk);
        u_if.in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(u_if.in_ready), 64'd1);
        chk("arst_out_valid", 64'(u_if.out_valid), 64'd0);
        chk("arst_diff", 64'(u_if.diff), 64'd0);
        chk("arst_flags", {61'd0, u_if.borrow, u_if.ovf, u_if.zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(32'd10, 32'd4, lat);
        chk("post_rst_latency", 64'(lat), 64'(NCH));
        chk("post_rst_diff", 64'(u_if.diff), 64'd6);
        chk("post_rst_flags", {61'd0, u_if.borrow, u_if.ovf, u_if.zero}, 64'd0);
        retire();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends with a summary.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_sub32.md
Name: serial_sub32

Overview:
- Multi-cycle chunked subtractor: computes a - b over WIDTH bits, CHUNK bits per clock, with a registered borrow between chunks.
- Counterpart to the team's 32-bit adders; serves as the ALU's subtract/compare path where area matters more than latency.
- Valid/ready handshake on input and output. Produces difference plus borrow, signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits subtracted per clock; N = WIDTH/CHUNK chunk cycles per operation (default N = 4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a, b valid this cycle.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff a < b unsigned.
- ovf  output  1  signed overflow of a - b.
- zero  output  1  diff == 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n = 0, takes effect immediately without waiting for clk):
  - state = IDLE; in_ready = 1; out_valid = 0; diff = 0; borrow = 0; ovf = 0; zero = 0.
  - Internal operand registers, chunk index and borrow register are cleared.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid = 1: capture a and b into internal registers, clear chunk index and borrow register, go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge processes chunk i, where bits [i*CHUNK +: CHUNK] are subtracted.
  - A (CHUNK+1)-bit result t = {0,a_i} - {0,b_i} - borrow_reg.
  - diff chunk i <= t[CHUNK-1:0]; borrow_reg <= t[CHUNK].
  - i increments by 1. After the edge processing i = N-1, go to DONE.
  - Chunks are processed LSB first.
- DONE:
  - out_valid = 1.
  - borrow = borrow_reg.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the captured operands.
  - zero = (diff == 0).
  - On an edge with out_ready = 1: go to IDLE and drop out_valid.
  - diff and the flags keep their values until the next operation writes them.
- Latency:
  - Operands are accepted on edge k; out_valid is high after edge k+N (4 cycles at defaults).
  - Throughput is one operation per N+2 cycles minimum.
- in_ready is 0 throughout RUN and DONE; in_valid is ignored there. No overlap between operations, and no simultaneous accept and retire.
- Changes on a or b after capture have no effect on the operation in flight.
- While out_valid = 1 and out_ready = 0:
  - diff, borrow, ovf and zero stay stable for any number of cycles.
  - State remains DONE.
- Reset asserted mid-RUN or in DONE: the operation is aborted and the reset values above apply. The first operation after rst_n deasserts behaves normally.
- Wrap-around: the result is modulo 2^WIDTH. Borrow and overflow only appear in the flags, never in diff.

Test Plan:
- Inter-chunk borrow: a=0x00000100, b=0x00000001 -> diff=0x000000FF, borrow=0, ovf=0, zero=0; out_valid rises exactly 4 cycles after accept.
- Unsigned underflow: a=0x00000003, b=0x00000005 -> diff=0xFFFFFFFE, borrow=1, ovf=0, zero=0.
- Signed overflow: a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, borrow=0, ovf=1. Also a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow=1, ovf=1.
- Equality: a=b=0x12345678 -> diff=0x00000000, zero=1, borrow=0, ovf=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Required: outputs hold and in_ready=0 throughout; the new operands are not captured.
  - After out_ready=1, one idle cycle, then the new operation is accepted.
- Async reset: drop rst_n between clock edges during the 2nd RUN cycle -> in_ready=1 and out_valid=0 with no clock edge; then a=10, b=4 -> diff=6, flags 0.
